cfg_spi_bridge: RTL



---
 rtl/cfg_pkg.sv | 38 +++
 rtl/cfg_spi_bridge_if.sv | 30 +++
 rtl/sync_edge.sv | 38 +++
 rtl/cfg_spi_bridge.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants, state and register-name types for cfg_spi_bridge
// Purpose: frame geometry, FSM state encoding, config_reg register map and reset image.
// Ports: none (package).
package cfg_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 20;
  localparam int HDR_LEN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_WDATA,
    ST_RDATA,
    ST_COMMIT,
    ST_DONE
  } state_t;

  typedef enum logic [ADDR_W-1:0] {
    ADC0_REG       = 3'd0,
    ADC1_REG       = 3'd1,
    ADC2_REG       = 3'd2,
    ADC3_REG       = 3'd3,
    ID_REG         = 3'd4,
    GAIN_REG       = 3'd5,
    OFFSET_REG     = 3'd6,
    DIGITAL_CONFIG = 3'd7
  } reg_name_t;

  // Reset image of config_reg, indexed by register address.
  localparam logic [DATA_W-1:0] RESET_VALS [8] = '{
    16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
    16'hABCD, 16'h0000, 16'h0000, 16'h0001
  };

endpackage

// File: rtl/cfg_spi_bridge_if.sv
// rtl/cfg_spi_bridge_if.sv - serial host pins plus config_reg bus of cfg_spi_bridge
// Purpose: bundles the SPI-side pins and the register-side bus.
// Modports: master = bridge (drives miso/miso_oe/write/address/data_in/busy/frame_err),
//           slave  = host + config_reg environment (drives sclk/cs_n/mosi/data_out).
interface cfg_spi_bridge_if;
  import cfg_pkg::*;

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              frame_err;

  modport master (
    input  sclk, cs_n, mosi, data_out,
    output miso, miso_oe, write, address, data_in, busy, frame_err
  );

  modport slave (
    output sclk, cs_n, mosi, data_out,
    input  miso, miso_oe, write, address, data_in, busy, frame_err
  );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detection
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports: clk, reset (async high), d (async in), q (synced level), rise/fall (1-clk pulses).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chain resets low: a pin already low at reset release yields no falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/cfg_spi_bridge.sv
// rtl/cfg_spi_bridge.sv - 20-bit SPI-style frame decoder driving config_reg
// Purpose: oversamples sclk/cs_n/mosi, decodes rw/address/data frames into one-cycle
//          register writes or 16-bit reads shifted out on miso.
// Ports: clk, reset (async high), bus (cfg_spi_bridge_if.master: serial pins + register bus).
module cfg_spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  cfg_spi_bridge_if.master        bus
);
  import cfg_pkg::*;

  localparam logic [4:0] HDR_LAST   = 5'(HDR_LEN - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_LEN - 1);
  localparam logic [4:0] HDR_BITS   = 5'(HDR_LEN);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_q, cs_rise, cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(bus.sclk),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .d(bus.cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi needs no edge detect; same depth keeps it aligned with the synced sclk edges.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              wait_q, wait_d;
  logic              extra_q, extra_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    shift_d     = shift_q;
    wait_d      = wait_q;
    extra_d     = extra_q;
    write_d     = 1'b0;
    address_d   = address_q;
    data_in_d   = data_in_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};

    case (state_q)
      ST_IDLE: if (cs_fall) begin
        state_d = ST_HDR;
        busy_d  = 1'b1;
        cnt_d   = '0;
        extra_d = 1'b0;
      end
      // hdr_q holds only the address; rw is the bit that falls out of its top on the 4th edge.
      ST_HDR: if (sclk_rise) begin
        hdr_d = {hdr_q[ADDR_W-2:0], mosi_s};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == HDR_LAST) begin
          if (hdr_q[ADDR_W-1]) begin
            state_d = ST_WDATA;
          end else begin
            state_d   = ST_LOAD;
            address_d = {hdr_q[ADDR_W-2:0], mosi_s};
            wait_d    = 1'b0;
          end
        end
      end
      // Two cycles of settle time for config_reg's read path after address changes.
      ST_LOAD: if (wait_q) begin
        shift_d   = {bus.data_out[DATA_W-2:0], 1'b0};
        miso_d    = bus.data_out[DATA_W-1];
        miso_oe_d = 1'b1;
        state_d   = ST_RDATA;
      end else begin
        wait_d = 1'b1;
      end
      ST_WDATA: if (sclk_rise) begin
        shift_d = {shift_q[DATA_W-2:0], mosi_s};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == FRAME_LAST) begin
          state_d   = ST_COMMIT;
          write_d   = 1'b1;
          address_d = hdr_q;
          data_in_d = {shift_q[DATA_W-2:0], mosi_s};
        end
      end
      // The falling edge right after the last header bit arrives here too; bit 15 is
      // already on miso, so shifting starts with the fall following the 5th rise.
      ST_RDATA: begin
        if (sclk_fall && cnt_q > HDR_BITS) begin
          miso_d  = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == FRAME_LAST) state_d = ST_DONE;
        end
      end
      ST_COMMIT: state_d = ST_DONE;
      ST_DONE: begin
        if (sclk_rise) extra_d = 1'b1;
        if (cs_q) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          miso_oe_d   = 1'b0;
          miso_d      = 1'b0;
          frame_err_d = extra_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Short frame: drop everything, including a header address picked up this cycle.
    if (cs_rise && (state_q == ST_HDR || state_q == ST_LOAD ||
                    state_q == ST_WDATA || state_q == ST_RDATA)) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      miso_oe_d   = 1'b0;
      miso_d      = 1'b0;
      frame_err_d = 1'b1;
      write_d     = 1'b0;
      address_d   = address_q;
      data_in_d   = data_in_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      shift_q     <= '0;
      wait_q      <= 1'b0;
      extra_q     <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= '0;
      data_in_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      shift_q     <= shift_d;
      wait_q      <= wait_d;
      extra_q     <= extra_d;
      write_q     <= write_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign bus.write     = write_q;
  assign bus.address   = address_q;
  assign bus.data_in   = data_in_q;
  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule
